// File: rtl/tinker_mem_responder.sv
// tinker_mem_responder
//
// Memory-side end of the Tinker core's instruction-fetch and data load/store interface.
// A big-endian byte array serves one request at a time. A request is accepted over a
// valid/ready handshake, and a one-cycle response pulse follows LATENCY rising edges later.
// The data port has fixed priority over the fetch port.
//
// Parameters
//   MEM_BYTES   byte-array size; valid addresses are 0..MEM_BYTES-1 (at least 8)
//   LATENCY     rising edges from acceptance to response, 1..15
//   INIT_FILE   memory image name; reset never clears the array
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   i_req_valid/ready/addr      fetch request channel (32-bit byte address)
//   i_rsp_valid/data/err        fetch response pulse; data {m[a],m[a+1],m[a+2],m[a+3]}
//   d_req_valid/ready/we/addr   data request channel (we=1 store, we=0 load)
//   d_req_wdata                 64-bit store data; bits [63:56] land at addr
//   d_rsp_valid/data/err        data response pulse, for loads and stores; data 0 for stores
module tinker_mem_responder #(
    parameter int unsigned MEM_BYTES = 524288,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [63:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [63:0] d_rsp_data,
    output logic        d_rsp_err
);

    localparam int unsigned AW      = $clog2(MEM_BYTES);
    // Highest legal start address for a 4-byte fetch and an 8-byte data access.
    localparam logic [31:0] I_LIMIT = 32'(MEM_BYTES - 4);
    localparam logic [31:0] D_LIMIT = 32'(MEM_BYTES - 8);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        port_q, port_d;    // 1 = data port, 0 = fetch port
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q;           // fetch data occupies [63:32]

    logic        d_fire, i_fire;
    logic        err_lat;
    logic        mem_edge;

    logic [7:0]  mem [MEM_BYTES];

    // Readies and handshakes
    always_comb begin
        d_req_ready = (state_q == StIdle);
        i_req_ready = (state_q == StIdle) && !d_req_valid;
        d_fire      = d_req_valid && d_req_ready;
        i_fire      = i_req_valid && i_req_ready;
    end

    // Range check on the latched request; unsigned 32-bit compare, so no wrap-around.
    always_comb begin
        err_lat = port_q ? (addr_q > D_LIMIT) : (addr_q > I_LIMIT);
    end

    // The array access happens on the edge that leaves BUSY.
    assign mem_edge = (state_q == StBusy) && (cnt_q == 4'd0);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (d_fire) begin
                    port_d  = 1'b1;
                    we_d    = d_req_we;
                    addr_d  = d_req_addr;
                    wdata_d = d_req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = StBusy;
                end else if (i_fire) begin
                    port_d  = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = i_req_addr;
                    wdata_d = '0;
                    cnt_d   = CNT_INIT;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Byte array and read capture. No reset: the array survives reset, and rdata_q is only
    // visible while a response is valid. While reset is held the FSM sits in IDLE, so a
    // pending store cannot reach its write edge.
    always_ff @(posedge clk) begin
        if (mem_edge) begin
            for (int k = 0; k < 8; k++) begin
                if (port_q && we_q && !err_lat) begin
                    mem[addr_q[AW-1:0] + AW'(k)] <= wdata_q[63-8*k -: 8];
                end
                // Fetch reads only 4 bytes so it never touches past the top of the array.
                if (!we_q && !err_lat && (port_q || k < 4)) begin
                    rdata_q[63-8*k -: 8] <= mem[addr_q[AW-1:0] + AW'(k)];
                end else begin
                    rdata_q[63-8*k -: 8] <= 8'h00;
                end
            end
        end
    end

    // Response outputs, forced to zero outside the response cycle.
    always_comb begin
        d_rsp_valid = (state_q == StResp) && port_q;
        i_rsp_valid = (state_q == StResp) && !port_q;
        d_rsp_data  = d_rsp_valid ? rdata_q : 64'd0;
        i_rsp_data  = i_rsp_valid ? rdata_q[63:32] : 32'd0;
        d_rsp_err   = d_rsp_valid && err_lat;
        i_rsp_err   = i_rsp_valid && err_lat;
    end

endmodule

// File: tb/tb_tinker_mem_responder.sv
module tb_tinker_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        rst_aux;
    int          cyc;
    int          checks;
    int          failures;

    // Main DUT (LATENCY=2, full size)
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata, d_rsp_data;

    // Throughput DUTs (LATENCY=1 and 15) with a held-high load request
    logic        aux_valid;
    logic        a1_i_rdy, a1_i_rv, a1_i_err, a1_d_rdy, a1_d_rv, a1_d_err;
    logic [31:0] a1_i_data;
    logic [63:0] a1_d_data;
    logic        a15_i_rdy, a15_i_rv, a15_i_err, a15_d_rdy, a15_d_rv, a15_d_err;
    logic [31:0] a15_i_data;
    logic [63:0] a15_d_data;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    tinker_mem_responder #(.MEM_BYTES(524288), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
    );

    tinker_mem_responder #(.MEM_BYTES(4096), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(rst_aux),
        .i_req_valid(1'b0), .i_req_ready(a1_i_rdy), .i_req_addr(32'h0),
        .i_rsp_valid(a1_i_rv), .i_rsp_data(a1_i_data), .i_rsp_err(a1_i_err),
        .d_req_valid(aux_valid), .d_req_ready(a1_d_rdy), .d_req_we(1'b0),
        .d_req_addr(32'h10), .d_req_wdata(64'h0),
        .d_rsp_valid(a1_d_rv), .d_rsp_data(a1_d_data), .d_rsp_err(a1_d_err)
    );

    tinker_mem_responder #(.MEM_BYTES(4096), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(rst_aux),
        .i_req_valid(1'b0), .i_req_ready(a15_i_rdy), .i_req_addr(32'h0),
        .i_rsp_valid(a15_i_rv), .i_rsp_data(a15_i_data), .i_rsp_err(a15_i_err),
        .d_req_valid(aux_valid), .d_req_ready(a15_d_rdy), .d_req_we(1'b0),
        .d_req_addr(32'h10), .d_req_wdata(64'h0),
        .d_rsp_valid(a15_d_rv), .d_rsp_data(a15_d_data), .d_rsp_err(a15_d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Data-port request; returns at the falling edge after acceptance.
    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_data, input bit exp_err, input bit push);
        int   n;
        exp_t e;
        d_req_we    = we;
        d_req_addr  = addr;
        d_req_wdata = wdata;
        d_req_valid = 1'b1;
        n = 0;
        #1;
        while (!d_req_ready) begin
            if (n >= 200) begin
                check("d_accept_timeout", 64'd0, 64'd1);
                d_req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        if (push) begin
            e.is_d = 1'b1;
            e.data = exp_data;
            e.err  = exp_err;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
        d_req_valid = 1'b0;
    endtask

    task automatic issue_i(input logic [31:0] addr, input logic [31:0] exp_data,
                           input bit exp_err);
        int   n;
        exp_t e;
        i_req_addr  = addr;
        i_req_valid = 1'b1;
        n = 0;
        #1;
        while (!i_req_ready) begin
            if (n >= 200) begin
                check("i_accept_timeout", 64'd0, 64'd1);
                i_req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        e.is_d = 1'b0;
        e.data = {32'd0, exp_data};
        e.err  = exp_err;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
        i_req_valid = 1'b0;
    endtask

    // Scoreboard monitor for the main DUT
    always @(negedge clk) begin
        if (!reset) begin
            if (i_rsp_valid || d_rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got i_valid=%0b d_valid=%0b expected none",
                             i_rsp_valid, d_rsp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_port", {62'd0, i_rsp_valid, d_rsp_valid},
                          mon_e.is_d ? 64'd1 : 64'd2);
                    check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (mon_e.is_d) begin
                        check("d_rsp_data", d_rsp_data, mon_e.data);
                        check("d_rsp_err", {63'd0, d_rsp_err}, {63'd0, mon_e.err});
                    end else begin
                        check("i_rsp_data", {32'd0, i_rsp_data}, mon_e.data);
                        check("i_rsp_err", {63'd0, i_rsp_err}, {63'd0, mon_e.err});
                    end
                end
            end
            if (!i_rsp_valid) check("i_rsp_quiet", {31'd0, i_rsp_err, i_rsp_data}, 64'd0);
            if (!d_rsp_valid) check("d_rsp_quiet", d_rsp_data | {63'd0, d_rsp_err}, 64'd0);
            if (d_req_valid) check("i_ready_blocked", {63'd0, i_req_ready}, 64'd0);
        end
    end

    // Throughput monitors: acceptances spaced LATENCY+2 apart, one pulse in between.
    bit tput_on;
    int last1 = -1, rsp1 = 0, acc1 = 0;
    int last15 = -1, rsp15 = 0, acc15 = 0;

    always @(negedge clk) begin
        if (tput_on) begin
            if (a1_d_rv) begin
                rsp1++;
                check("l1_err", {63'd0, a1_d_err}, 64'd0);
            end
            if (a1_d_rdy) begin
                if (last1 >= 0) begin
                    check("l1_spacing", 64'(cyc - last1), 64'd3);
                    check("l1_one_rsp", 64'(rsp1), 64'd1);
                end
                last1 = cyc;
                rsp1  = 0;
                acc1++;
            end
            if (a15_d_rv) begin
                rsp15++;
                check("l15_err", {63'd0, a15_d_err}, 64'd0);
            end
            if (a15_d_rdy) begin
                if (last15 >= 0) begin
                    check("l15_spacing", 64'(cyc - last15), 64'd17);
                    check("l15_one_rsp", 64'(rsp15), 64'd1);
                end
                last15 = cyc;
                rsp15  = 0;
                acc15++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cyc         = 0;
        checks      = 0;
        failures    = 0;
        tput_on     = 1'b0;
        reset       = 1'b1;
        rst_aux     = 1'b1;
        aux_valid   = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = '0;
        d_req_wdata = '0;

        @(negedge clk);
        #1;
        check("reset_rsp", {i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err, 60'd0}
              | {32'd0, i_rsp_data} | d_rsp_data, 64'd0);
        check("reset_readies", {62'd0, i_req_ready, d_req_ready}, 64'd3);
        @(negedge clk);
        reset     = 1'b0;
        rst_aux   = 1'b0;
        aux_valid = 1'b1;

        fork
            begin
                repeat (3) @(posedge clk);
                tput_on = 1'b1;
                repeat (120) @(posedge clk);
                tput_on = 1'b0;
            end
            begin
                // Preload, fetch, store/load round trip, unaligned fetch
                issue_d(1'b1, 32'h2000, 64'h11223344_55667788, 64'd0, 1'b0, 1'b1);
                issue_i(32'h2000, 32'h11223344, 1'b0);
                issue_d(1'b1, 32'h100, 64'h01020304_05060708, 64'd0, 1'b0, 1'b1);
                issue_d(1'b0, 32'h100, 64'd0, 64'h01020304_05060708, 1'b0, 1'b1);
                issue_i(32'h100, 32'h01020304, 1'b0);
                issue_i(32'h104, 32'h05060708, 1'b0);
                issue_i(32'h2002, 32'h33445566, 1'b0);

                // Simultaneous requests: data wins, fetch served next
                fork
                    issue_d(1'b0, 32'h100, 64'd0, 64'h01020304_05060708, 1'b0, 1'b1);
                    issue_i(32'h2000, 32'h11223344, 1'b0);
                join

                // Range boundaries
                issue_d(1'b1, 32'h7FFF8, 64'h0F1E2D3C_4B5A6978, 64'd0, 1'b0, 1'b1);
                issue_d(1'b0, 32'h7FFF9, 64'd0, 64'd0, 1'b1, 1'b1);
                issue_d(1'b0, 32'h7FFF8, 64'd0, 64'h0F1E2D3C_4B5A6978, 1'b0, 1'b1);
                issue_d(1'b1, 32'h7FFFC, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 1'b1);
                issue_i(32'h7FFFC, 32'h4B5A6978, 1'b0);
                issue_i(32'h7FFFD, 32'h0, 1'b1);
                issue_d(1'b0, 32'hFFFFFFFF, 64'd0, 64'd0, 1'b1, 1'b1);

                // Reset during BUSY of a store drops it
                issue_d(1'b1, 32'h200, 64'hA5A5A5A5_5A5A5A5A, 64'd0, 1'b0, 1'b1);
                issue_d(1'b1, 32'h200, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 1'b0);
                reset = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("rst_readies", {62'd0, i_req_ready, d_req_ready}, 64'd3);
                    check("rst_no_rsp", {62'd0, i_rsp_valid, d_rsp_valid}, 64'd0);
                    @(negedge clk);
                end
                reset = 1'b0;
                issue_d(1'b0, 32'h200, 64'd0, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1);
                issue_i(32'h204, 32'h5A5A5A5A, 1'b0);
            end
        join

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("l1_accepts", 64'(acc1 >= 35), 64'd1);
        check("l15_accepts", 64'(acc15 >= 6), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
